// File: rtl/generic_mul_pipe.sv
// generic_mul_pipe: LANES-wide pipelined GF(2^BIT_WIDTH) multiplier with valid/ready handshake.
//
// Field arithmetic per lane:
//   BIT_WIDTH 1: GF(2),  product = a & b
//   BIT_WIDTH 2: GF(4),  polynomial basis, reduction polynomial x^2 + x + 1
//   BIT_WIDTH 4: GF(16), polynomial basis, reduction polynomial x^4 + x + 1
//
// Ports:
//   in_clock, in_reset   clock, synchronous active-high reset
//   in_valid, out_ready  upstream handshake (accept = in_valid & out_ready)
//   in_a, in_b           packed operands, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   in_square            1: multiply a by itself, in_b ignored
//   out_valid, in_ready  downstream handshake (transfer = out_valid & in_ready)
//   out_c                packed products from the last stage
//   out_count            number of occupied stages
module generic_mul_pipe #(
    parameter int unsigned BIT_WIDTH = 2,
    parameter int unsigned LANES     = 4,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                       in_clock,
    input  logic                       in_reset,
    input  logic                       in_valid,
    output logic                       out_ready,
    input  logic [LANES*BIT_WIDTH-1:0] in_a,
    input  logic [LANES*BIT_WIDTH-1:0] in_b,
    input  logic                       in_square,
    output logic                       out_valid,
    input  logic                       in_ready,
    output logic [LANES*BIT_WIDTH-1:0] out_c,
    output logic [2:0]                 out_count
);

    localparam int unsigned W = LANES * BIT_WIDTH;

    if (!(BIT_WIDTH == 1 || BIT_WIDTH == 2 || BIT_WIDTH == 4)) begin : g_bad_width
        $error("generic_mul_pipe: BIT_WIDTH must be 1, 2 or 4");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("generic_mul_pipe: LATENCY must be in 1..4");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("generic_mul_pipe: LANES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Per-lane field multipliers (purely combinational, feed stage 0)
    // ------------------------------------------------------------------
    logic [W-1:0] prod;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [BIT_WIDTH-1:0] a;
        logic [BIT_WIDTH-1:0] b;
        logic [BIT_WIDTH-1:0] c;

        assign a = in_a[i*BIT_WIDTH +: BIT_WIDTH];
        assign b = in_square ? a : in_b[i*BIT_WIDTH +: BIT_WIDTH];

        if (BIT_WIDTH == 1) begin : g_gf2
            assign c = a & b;
        end else if (BIT_WIDTH == 2) begin : g_gf4
            // x^2 folds back as x + 1
            assign c[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
            assign c[0] = (a[0] & b[0]) ^ (a[1] & b[1]);
        end else if (BIT_WIDTH == 4) begin : g_gf16
            logic [6:0] p;  // carry-less product before reduction
            assign p[0] = a[0] & b[0];
            assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign p[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
            assign p[3] = (a[3] & b[0]) ^ (a[2] & b[1]) ^ (a[1] & b[2]) ^ (a[0] & b[3]);
            assign p[4] = (a[3] & b[1]) ^ (a[2] & b[2]) ^ (a[1] & b[3]);
            assign p[5] = (a[3] & b[2]) ^ (a[2] & b[3]);
            assign p[6] = a[3] & b[3];
            // x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2
            assign c[0] = p[0] ^ p[4];
            assign c[1] = p[1] ^ p[4] ^ p[5];
            assign c[2] = p[2] ^ p[5] ^ p[6];
            assign c[3] = p[3] ^ p[6];
        end else begin : g_gf_none
            assign c = '0;
        end

        assign prod[i*BIT_WIDTH +: BIT_WIDTH] = c;
    end

    // ------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [W-1:0]       data_q [LATENCY];
    logic [W-1:0]       data_d [LATENCY];
    logic [LATENCY-1:0] adv;
    logic               accept;
    logic [2:0]         count;

    // A stage advances when the one after it is empty or itself advancing,
    // so bubbles collapse; evaluated from the output end backwards.
    always_comb begin
        adv = '0;
        adv[LATENCY-1] = in_ready;
        for (int k = int'(LATENCY) - 2; k >= 0; k--) begin
            adv[k] = !vld_q[k+1] || adv[k+1];
        end
    end

    // Holding reset forces out_ready low so nothing is accepted meanwhile.
    assign out_ready = !in_reset && (!vld_q[0] || adv[0]);
    assign accept    = in_valid && out_ready;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (accept) begin
            vld_d[0]  = 1'b1;
            data_d[0] = prod;
        end else if (adv[0]) begin
            vld_d[0] = 1'b0;
        end
        // A stage that advances always has its successor loading from it,
        // so downstream stages only ever load or hold.
        for (int k = 1; k < int'(LATENCY); k++) begin
            if (adv[k-1]) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            vld_q <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < int'(LATENCY); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < int'(LATENCY); k++) begin
            count = count + {2'b00, vld_q[k]};
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_c     = data_q[LATENCY-1];
    assign out_count = count;

endmodule

// File: tb/tb_generic_mul_pipe.sv
// Bench for generic_mul_pipe. Four instances share one stimulus bus:
//   p42: BIT_WIDTH 4, LATENCY 2    p43: BIT_WIDTH 4, LATENCY 3
//   p1 : BIT_WIDTH 1, LATENCY 1    p2 : BIT_WIDTH 2, LATENCY 1    (all LANES 4)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_generic_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic        ready;
    logic        sq;
    logic [15:0] a;
    logic [15:0] b;

    logic        p42_ready, p42_valid;
    logic [15:0] p42_c;
    logic [2:0]  p42_cnt;
    logic        p43_ready, p43_valid;
    logic [15:0] p43_c;
    logic [2:0]  p43_cnt;
    logic        p1_ready, p1_valid;
    logic [3:0]  p1_c;
    logic [2:0]  p1_cnt;
    logic        p2_ready, p2_valid;
    logic [7:0]  p2_c;
    logic [2:0]  p2_cnt;

    generic_mul_pipe #(.BIT_WIDTH(4), .LANES(4), .LATENCY(2)) u_p42 (
        .in_clock(clk), .in_reset(rst), .in_valid(valid), .out_ready(p42_ready),
        .in_a(a), .in_b(b), .in_square(sq), .out_valid(p42_valid), .in_ready(ready),
        .out_c(p42_c), .out_count(p42_cnt)
    );
    generic_mul_pipe #(.BIT_WIDTH(4), .LANES(4), .LATENCY(3)) u_p43 (
        .in_clock(clk), .in_reset(rst), .in_valid(valid), .out_ready(p43_ready),
        .in_a(a), .in_b(b), .in_square(sq), .out_valid(p43_valid), .in_ready(ready),
        .out_c(p43_c), .out_count(p43_cnt)
    );
    generic_mul_pipe #(.BIT_WIDTH(1), .LANES(4), .LATENCY(1)) u_p1 (
        .in_clock(clk), .in_reset(rst), .in_valid(valid), .out_ready(p1_ready),
        .in_a(a[3:0]), .in_b(b[3:0]), .in_square(sq), .out_valid(p1_valid), .in_ready(ready),
        .out_c(p1_c), .out_count(p1_cnt)
    );
    generic_mul_pipe #(.BIT_WIDTH(2), .LANES(4), .LATENCY(1)) u_p2 (
        .in_clock(clk), .in_reset(rst), .in_valid(valid), .out_ready(p2_ready),
        .in_a(a[7:0]), .in_b(b[7:0]), .in_square(sq), .out_valid(p2_valid), .in_ready(ready),
        .out_c(p2_c), .out_count(p2_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference field multiply by shift-and-add with polynomial reduction.
    function automatic logic [3:0] gf_ref(input int bw, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] r;
        logic [4:0] poly;
        r = '0;
        case (bw)
            4:       poly = 5'b10011;
            2:       poly = 5'b00111;
            default: poly = 5'b00011;
        endcase
        for (int i = bw - 1; i >= 0; i--) begin
            r = r << 1;
            if (r[bw]) r = r ^ poly;
            if (y[i]) r = r ^ {1'b0, x};
        end
        return r[3:0];
    endfunction

    function automatic logic [15:0] mul_ref(input int bw, input logic [15:0] x,
                                            input logic [15:0] y, input logic s);
        logic [15:0] r;
        logic [15:0] mask;
        logic [3:0]  la, lb;
        r    = '0;
        mask = 16'((1 << bw) - 1);
        for (int l = 0; l < 4; l++) begin
            la = 4'((x >> (l * bw)) & mask);
            lb = s ? la : 4'((y >> (l * bw)) & mask);
            r  = r | (16'(gf_ref(bw, la, lb)) << (l * bw));
        end
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Single operation with in_ready=1; records first result and its latency per instance.
    int          lat42, lat43, lat1, lat2;
    logic [15:0] got42, got43;
    logic [3:0]  got1;
    logic [7:0]  got2;

    task automatic one_op(input logic [15:0] oa, input logic [15:0] ob, input logic osq);
        lat42 = -1; lat43 = -1; lat1 = -1; lat2 = -1;
        got42 = '0; got43 = '0; got1 = '0; got2 = '0;
        next_cycle();
        valid = 1'b1; a = oa; b = ob; sq = osq; ready = 1'b1;
        sample();
        check("op accept", 32'(p42_ready), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            // Scramble operands after accept: stored results must not change.
            valid = 1'b0; a = ~oa; b = 16'($urandom); sq = ~osq;
            sample();
            if (p42_valid && lat42 < 0) begin lat42 = k; got42 = p42_c; end
            if (p43_valid && lat43 < 0) begin lat43 = k; got43 = p43_c; end
            if (p1_valid && lat1 < 0) begin lat1 = k; got1 = p1_c; end
            if (p2_valid && lat2 < 0) begin lat2 = k; got2 = p2_c; end
        end
    endtask

    logic [15:0] sa [16];
    logic [15:0] sb [16];
    logic [15:0] se [16];
    logic [15:0] q [$];
    logic [15:0] exp_v;
    logic [15:0] prev_c;
    logic        prev_stall;
    logic        hold, gap;
    int          idx, rx;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid = 1'b1; ready = 1'b1; sq = 1'b0; a = 16'h1234; b = 16'h5678;

        // 1: reset held two cycles with in_valid high
        repeat (2) begin
            next_cycle();
            sample();
            check("rst out_valid", 32'(p42_valid), 32'd0);
            check("rst out_c", 32'(p42_c), 32'd0);
            check("rst out_count", 32'(p42_cnt), 32'd0);
            check("rst out_ready", 32'(p42_ready), 32'd0);
        end
        next_cycle();
        rst = 1'b0; valid = 1'b0;
        sample();
        check("post-rst out_ready", 32'(p42_ready), 32'd1);
        check("post-rst out_ready L3", 32'(p43_ready), 32'd1);

        // 2: 16-item stream, latency 2 and full throughput
        for (int i = 0; i < 16; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            se[i] = mul_ref(4, sa[i], sb[i], 1'b0);
        end
        sa[0] = 16'h8F22; sb[0] = 16'h2F83; se[0] = 16'h3A36;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            valid = (c < 16); ready = 1'b1; sq = 1'b0;
            if (c < 16) begin a = sa[c]; b = sb[c]; end
            sample();
            if (c < 16) check("stream ready", 32'(p42_ready), 32'd1);
            check("stream out_valid", 32'(p42_valid), 32'(c >= 2 && c < 18));
            if (c >= 2 && c < 18) check("stream data", 32'(p42_c), 32'(se[c-2]));
        end

        // 3: zero operand, then square mode with in_b ignored
        one_op(16'hA5C3, 16'h0000, 1'b0);
        check("zero data", 32'(got42), 32'h0000);
        check("zero latency L2", 32'(lat42), 32'd2);
        check("zero latency L3", 32'(lat43), 32'd3);
        one_op(16'hA5C3, 16'hFFFF, 1'b1);
        check("square data L2", 32'(got42), 32'h82F5);
        check("square data L3", 32'(got43), 32'h82F5);

        // 4: backpressure on the LATENCY=3 instance
        for (int i = 0; i < 5; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            se[i] = mul_ref(4, sa[i], sb[i], 1'b0);
        end
        ready = 1'b0; sq = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            valid = 1'b1; a = sa[idx]; b = sb[idx];
            sample();
            if (p43_ready) idx++;
        end
        check("bp accepted", 32'(idx), 32'd3);
        check("bp count", 32'(p43_cnt), 32'd3);
        check("bp out_ready", 32'(p43_ready), 32'd0);
        check("bp out_valid", 32'(p43_valid), 32'd1);
        check("bp head", 32'(p43_c), 32'(se[0]));
        repeat (2) begin
            next_cycle();
            sample();
            check("bp frozen", 32'(p43_c), 32'(se[0]));
            check("bp frozen count", 32'(p43_cnt), 32'd3);
        end
        rx = 0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            ready = 1'b1; valid = (idx < 5);
            if (idx < 5) begin a = sa[idx]; b = sb[idx]; end
            sample();
            if (valid && p43_ready) begin
                check("bp late accept cycle", 32'(c), 32'(idx - 3));
                idx++;
            end
            if (p43_valid) begin
                if (rx < 5) check("bp order", 32'(p43_c), 32'(se[rx]));
                rx++;
            end
        end
        check("bp all accepted", 32'(idx), 32'd5);
        check("bp delivered", 32'(rx), 32'd5);

        // 5: alternating valid with random in_ready, scoreboarded
        valid = 1'b0; hold = 1'b0; gap = 1'b0; prev_stall = 1'b0; prev_c = '0;
        for (int c = 0; c < 1000; c++) begin
            next_cycle();
            if (!hold) begin
                if (gap) valid = 1'b0;
                else begin
                    valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sq = 1'($urandom);
                end
                gap = !gap;
            end
            ready = 1'($urandom_range(0, 1));
            sample();
            if (prev_stall) begin
                check("stall data", 32'(p42_c), 32'(prev_c));
                check("stall valid", 32'(p42_valid), 32'd1);
            end
            check("count bound", 32'(p42_cnt <= 3'd2), 32'd1);
            if (p42_valid && ready) begin
                check("sb nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    exp_v = q.pop_front();
                    check("sb data", 32'(p42_c), 32'(exp_v));
                end
            end
            if (valid && p42_ready) begin
                q.push_back(mul_ref(4, a, b, sq));
                hold = 1'b0;
            end else begin
                hold = valid;
            end
            prev_stall = p42_valid && !ready;
            prev_c     = p42_c;
        end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            valid = 1'b0; ready = 1'b1;
            sample();
            if (p42_valid) begin
                check("drain nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    exp_v = q.pop_front();
                    check("drain data", 32'(p42_c), 32'(exp_v));
                end
            end
        end
        check("sb empty", 32'(q.size()), 32'd0);

        // 6: reset with two items in flight
        next_cycle();
        valid = 1'b1; ready = 1'b0; sq = 1'b0; a = 16'h1111; b = 16'h2222;
        sample();
        check("mid accept 0", 32'(p42_ready), 32'd1);
        next_cycle();
        a = 16'h3333; b = 16'h4444;
        sample();
        check("mid accept 1", 32'(p42_ready), 32'd1);
        next_cycle();
        valid = 1'b1; rst = 1'b1; ready = 1'b1;
        sample();
        check("mid rst out_ready", 32'(p42_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            rst = 1'b0; valid = 1'b0;
            sample();
            check("mid flushed valid", 32'(p42_valid), 32'd0);
            check("mid flushed count", 32'(p42_cnt), 32'd0);
        end
        one_op(16'h8F22, 16'h2F83, 1'b0);
        check("post-flush data", 32'(got42), 32'h3A36);
        check("post-flush latency", 32'(lat42), 32'd2);

        // BIT_WIDTH 1 (AND) and BIT_WIDTH 2 (GF(4)) sweep
        one_op(16'h006C, 16'h00BA, 1'b0);
        check("bw1 v0", 32'(got1), 32'h8);
        check("bw2 v0", 32'(got2), 32'h94);
        check("bw1 latency", 32'(lat1), 32'd1);
        check("bw2 latency", 32'(lat2), 32'd1);
        one_op(16'h006E, 16'h00BE, 1'b0);
        check("bw1 v1", 32'(got1), 32'hE);
        check("bw2 v1", 32'(got2), 32'h9B);
        one_op(16'h006E, 16'h0000, 1'b1);
        check("bw1 square", 32'(got1), 32'hE);
        check("bw2 square", 32'(got2), 32'h7B);
        one_op(16'h000F, 16'h0006, 1'b0);
        check("bw1 v2", 32'(got1), 32'h6);
        check("bw2 v2", 32'(got2), 32'h0D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
